// File: rtl/btn_step_gen.sv
// Pushbutton debouncer with one-shot step pulse and hold-to-auto-repeat.
// Latency: DEBOUNCE_CYCLES+2 cycles from raw press to step; no backpressure (step is a free-running pulse).
// Backpressure: none; downstream must accept every step pulse.
module btn_step_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic step,
    output logic pressed,
    output logic repeat_active
);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST     = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RP_LAST     = 32'(REPEAT_PERIOD - 1);
    localparam logic        REPEAT_EN   = (REPEAT_DELAY != 0);
    localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

    state_t      state;
    logic [31:0] cnt;
    logic        sync_ff;
    logic        btn_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff       <= 1'b0;
            btn_s         <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            step          <= 1'b0;
            pressed       <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            sync_ff <= btn_in;
            btn_s   <= sync_ff;
            step    <= 1'b0;

            // Every branch tests btn_s==0 first so a release beats any step condition.
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end

                DB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= HELD;
                        cnt     <= '0;
                        step    <= 1'b1;
                        pressed <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                HELD: begin
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (REPEAT_EN && (cnt == RD_LAST)) begin
                        state         <= REPEAT;
                        cnt           <= '0;
                        step          <= 1'b1;
                        repeat_active <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 32'd1;
                    end
                end

                REPEAT: begin
                    if (!btn_s) begin
                        state         <= DB_RELEASE;
                        cnt           <= '0;
                        repeat_active <= 1'b0;
                    end else if (cnt == RP_LAST) begin
                        cnt  <= '0;
                        step <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                DB_RELEASE: begin
                    // A bounce back to 1 returns to HELD and restarts the repeat delay.
                    if (btn_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    pressed       <= 1'b0;
                    repeat_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_step_gen.sv
// Directed bench for btn_step_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5,
// plus a second instance with auto-repeat disabled.
module tb_btn_step_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_in = 1'b0;
    logic step, pressed, repeat_active;
    logic step_nr, pressed_nr, repeat_active_nr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .step(step), .pressed(pressed), .repeat_active(repeat_active)
    );

    btn_step_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)) dut_nr (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .step(step_nr), .pressed(pressed_nr), .repeat_active(repeat_active_nr)
    );

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        btn_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        btn_in = 1'b1;
        reset  = 1'b1;
        tick();
        checks++;
        if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", step); end
        checks++;
        if (pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b exp 0", pressed); end
        checks++;
        if (repeat_active !== 1'b0) begin errors++; $display("FAIL reset_repeat got %b exp 0", repeat_active); end
        // Button held through reset must produce a fresh press D+3 edges after the reset edge.
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (step !== (e == 7)) begin
                errors++; $display("FAIL held_thru_reset_step edge %0d got %b exp %b", e, step, (e == 7));
            end
        end
        do_reset();
    endtask

    task automatic test_clean_press;
        do_reset();
        for (int e = 0; e <= 20; e++) begin
            btn_in = (e <= 7);
            tick();
            checks++;
            if (step !== (e == 6)) begin
                errors++; $display("FAIL clean_step edge %0d got %b exp %b", e, step, (e == 6));
            end
            checks++;
            if (pressed !== (e >= 6 && e < 14)) begin
                errors++; $display("FAIL clean_pressed edge %0d got %b exp %b", e, pressed, (e >= 6 && e < 14));
            end
            checks++;
            if (repeat_active !== 1'b0) begin
                errors++; $display("FAIL clean_repeat edge %0d got %b exp 0", e, repeat_active);
            end
        end
    endtask

    task automatic test_bounce;
        logic [15:0] pat;
        do_reset();
        pat = 16'b0000_0011_1001_1001;  // pulses of 1, 2 and 3 cycles, bit 0 first
        for (int e = 0; e < 16; e++) begin
            btn_in = pat[e];
            tick();
            checks++;
            if (step !== 1'b0 || pressed !== 1'b0) begin
                errors++; $display("FAIL bounce edge %0d got step=%b pressed=%b exp 0/0", e, step, pressed);
            end
        end
        // A clean press afterwards must see full latency, proving the FSM went back to IDLE.
        for (int e = 0; e <= 9; e++) begin
            btn_in = 1'b1;
            tick();
            checks++;
            if (step !== (e == 6)) begin
                errors++; $display("FAIL bounce_recover_step edge %0d got %b exp %b", e, step, (e == 6));
            end
        end
        btn_in = 1'b0;
    endtask

    task automatic test_auto_repeat;
        int nsteps;
        logic exp_step;
        nsteps = 0;
        do_reset();
        for (int e = 0; e <= 45; e++) begin
            btn_in = (e <= 34);
            tick();
            exp_step = (e == 6) || (e == 16) || (e == 21) || (e == 26) || (e == 31) || (e == 36);
            if (step === 1'b1) nsteps++;
            checks++;
            if (step !== exp_step) begin
                errors++; $display("FAIL repeat_step edge %0d got %b exp %b", e, step, exp_step);
            end
            checks++;
            if (repeat_active !== (e >= 16 && e < 37)) begin
                errors++; $display("FAIL repeat_active edge %0d got %b exp %b", e, repeat_active, (e >= 16 && e < 37));
            end
            checks++;
            if (pressed !== (e >= 6 && e < 41)) begin
                errors++; $display("FAIL repeat_pressed edge %0d got %b exp %b", e, pressed, (e >= 6 && e < 41));
            end
        end
        checks++;
        if (nsteps != 6) begin errors++; $display("FAIL repeat_count got %0d exp 6", nsteps); end
    endtask

    task automatic test_release_bounce;
        do_reset();
        // FSM sees btn_in two edges late: DB_RELEASE at 10, HELD at 12, DB_RELEASE at 13, IDLE at 17.
        for (int e = 0; e <= 22; e++) begin
            btn_in = (e <= 7) || (e == 10);
            tick();
            checks++;
            if (step !== (e == 6)) begin
                errors++; $display("FAIL relbounce_step edge %0d got %b exp %b", e, step, (e == 6));
            end
            checks++;
            if (pressed !== (e >= 6 && e < 17)) begin
                errors++; $display("FAIL relbounce_pressed edge %0d got %b exp %b", e, pressed, (e >= 6 && e < 17));
            end
        end
    endtask

    task automatic test_reset_mid_repeat;
        do_reset();
        // Reset at edge 20 while in REPEAT; the repeat step due at 21 must not appear.
        for (int e = 0; e <= 32; e++) begin
            btn_in = 1'b1;
            reset  = (e == 20);
            tick();
            if (e == 20) begin
                checks++;
                if (step !== 1'b0 || pressed !== 1'b0 || repeat_active !== 1'b0) begin
                    errors++; $display("FAIL midrep_reset got %b%b%b exp 000", step, pressed, repeat_active);
                end
            end
            if (e > 20) begin
                checks++;
                if (step !== (e == 27)) begin
                    errors++; $display("FAIL midrep_step edge %0d got %b exp %b", e, step, (e == 27));
                end
                checks++;
                if (pressed !== (e >= 27)) begin
                    errors++; $display("FAIL midrep_pressed edge %0d got %b exp %b", e, pressed, (e >= 27));
                end
            end
        end
        reset = 1'b0;
        btn_in = 1'b0;
    endtask

    task automatic test_no_repeat;
        int nsteps;
        int nrep;
        nsteps = 0;
        nrep = 0;
        do_reset();
        for (int e = 0; e <= 110; e++) begin
            btn_in = (e < 100);
            tick();
            if (step_nr === 1'b1) nsteps++;
            if (repeat_active_nr !== 1'b0) nrep++;
            checks++;
            if (pressed_nr !== (e >= 6 && e < 106)) begin
                errors++; $display("FAIL norep_pressed edge %0d got %b exp %b", e, pressed_nr, (e >= 6 && e < 106));
            end
        end
        checks++;
        if (nsteps != 1) begin errors++; $display("FAIL norep_steps got %0d exp 1", nsteps); end
        checks++;
        if (nrep != 0) begin errors++; $display("FAIL norep_repeat_active got %0d cycles exp 0", nrep); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_repeat();
        test_no_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
